// File: rtl/fsb_cycle_ctl.sv
// fsb_cycle_ctl
//   Fast-bus cycle terminator for the MC68HC000 side of the accelerator.
//   It captures an address-strobe cycle and picks the lowest-index asserted
//   chip select. It inserts that channel's wait states, then ends the cycle
//   with nDTACK, nVPA (for VPA-mode channels or interrupt acknowledge) or
//   nBERR (for a channel error request or a timeout). The module also holds a
//   free-running DRAM refresh scheduler that does not depend on the bus FSM.
//
// Ports
//   i_fclk          fast bus clock, all logic on posedge
//   i_reset         asynchronous reset, active high
//   i_n_as          CPU address strobe, active low
//   i_iacs          interrupt-acknowledge cycle select
//   i_cs[NCH]       channel selects, active high
//   i_ready[NCH]    channel ready, active high
//   i_berr_in[NCH]  channel bus-error request, active high
//   o_n_dtack       registered data-transfer acknowledge, active low
//   o_n_vpa         registered valid-peripheral-address, active low
//   o_n_berr        registered bus error, active low
//   o_as_active     combinational ~nAS
//   o_as_inactive   combinational nAS & ~ASr (strobe high on two consecutive samples)
//   i_ref_ack       refresh performed this cycle
//   o_ref_req       refresh pending in the current period
//   o_ref_urgent    refresh pending and the period is past REF_URGENT
//   o_ref_miss      sticky: a refresh period expired unserved
//
// FSM states
//   state | meaning
//   IDLE  | waiting for the address strobe
//   WAIT  | cycle captured, counting wait states / timeout
//   TERM  | one termination strobe held low until the strobe is released

module fsb_cycle_ctl #(
    parameter int                   NCH        = 4,
    parameter int                   WSW        = 4,
    parameter logic [NCH*WSW-1:0]   WS         = '0,
    parameter logic [NCH-1:0]       VPAMASK    = '0,
    parameter int                   TOW        = 8,
    parameter int                   TIMEOUT    = 255,
    parameter int                   REF_PERIOD = 256,
    parameter int                   REF_URGENT = 128
) (
    input  logic           i_fclk,
    input  logic           i_reset,
    input  logic           i_n_as,
    input  logic           i_iacs,
    input  logic [NCH-1:0] i_cs,
    input  logic [NCH-1:0] i_ready,
    input  logic [NCH-1:0] i_berr_in,
    output logic           o_n_dtack,
    output logic           o_n_vpa,
    output logic           o_n_berr,
    output logic           o_as_active,
    output logic           o_as_inactive,
    input  logic           i_ref_ack,
    output logic           o_ref_req,
    output logic           o_ref_urgent,
    output logic           o_ref_miss
);

    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int RCW = (REF_PERIOD > 2) ? $clog2(REF_PERIOD) : 1;

    localparam logic [WSW:0]   WS_ONE   = {{WSW{1'b0}}, 1'b1};
    localparam logic [TOW-1:0] TO_ONE   = {{(TOW-1){1'b0}}, 1'b1};
    localparam logic [TOW-1:0] TO_LAST  = TOW'(TIMEOUT - 1);
    localparam logic [RCW-1:0] RC_ONE   = {{(RCW-1){1'b0}}, 1'b1};
    localparam logic [RCW-1:0] RC_LAST  = RCW'(REF_PERIOD - 1);
    localparam logic [RCW-1:0] RC_URG   = RCW'(REF_URGENT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        TERM = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_as;
    logic [CHW-1:0]   r_ch;
    logic             r_mapped;
    logic [WSW:0]     r_ws_cnt;
    logic [TOW-1:0]   r_to_cnt;
    logic             r_n_dtack;
    logic             r_n_vpa;
    logic             r_n_berr;

    logic [RCW-1:0]   r_ref_cnt;
    logic             r_ref_done;
    logic             r_ref_miss;

    logic             w_as_active;
    logic             w_as_inactive;
    logic             w_any_cs;
    logic [CHW-1:0]   w_sel;
    logic [WSW-1:0]   w_ws_load;
    logic             w_rdy;
    logic             w_berr;
    logic             w_vpa_mode;

    assign w_as_active   = ~i_n_as;
    assign w_as_inactive = i_n_as & ~r_as;

    // Lowest-index asserted select wins.
    always_comb begin
        w_any_cs = |i_cs;
        w_sel    = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (i_cs[i]) w_sel = CHW'(i);
        end
    end

    assign w_ws_load  = WS[int'(w_sel)*WSW +: WSW];
    assign w_rdy      = i_ready[r_ch];
    assign w_berr     = i_berr_in[r_ch];
    assign w_vpa_mode = VPAMASK[r_ch];

    always_ff @(posedge i_fclk or posedge i_reset) begin
        if (i_reset) r_as <= 1'b0;
        else         r_as <= ~i_n_as;
    end

    always_ff @(posedge i_fclk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= IDLE;
            r_ch      <= '0;
            r_mapped  <= 1'b0;
            r_ws_cnt  <= '0;
            r_to_cnt  <= '0;
            r_n_dtack <= 1'b1;
            r_n_vpa   <= 1'b1;
            r_n_berr  <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_as_active) begin
                        r_to_cnt <= '0;
                        if (i_iacs) begin
                            r_n_vpa <= 1'b0;
                            r_state <= TERM;
                        end else begin
                            r_mapped <= w_any_cs;
                            r_ch     <= w_sel;
                            // The extra count gives a fixed setup cycle, so
                            // a zero-wait channel terminates on the 2nd edge.
                            r_ws_cnt <= w_any_cs ? ({1'b0, w_ws_load} + WS_ONE) : '0;
                            r_state  <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    r_to_cnt <= r_to_cnt + TO_ONE;
                    if (r_ws_cnt != '0) r_ws_cnt <= r_ws_cnt - WS_ONE;
                    if (w_as_inactive) begin
                        r_state <= IDLE;
                    end else if (r_mapped && w_berr) begin
                        r_n_berr <= 1'b0;
                        r_state  <= TERM;
                    end else if (r_mapped && (r_ws_cnt == '0) && w_rdy) begin
                        if (w_vpa_mode) r_n_vpa   <= 1'b0;
                        else            r_n_dtack <= 1'b0;
                        r_state <= TERM;
                    end else if (r_to_cnt == TO_LAST) begin
                        r_n_berr <= 1'b0;
                        r_state  <= TERM;
                    end
                end
                TERM: begin
                    if (w_as_inactive) begin
                        r_n_dtack <= 1'b1;
                        r_n_vpa   <= 1'b1;
                        r_n_berr  <= 1'b1;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Refresh scheduler: a new period clears the served flag even if an ack
    // arrives on the same edge.
    always_ff @(posedge i_fclk or posedge i_reset) begin
        if (i_reset) begin
            r_ref_cnt  <= '0;
            r_ref_done <= 1'b0;
            r_ref_miss <= 1'b0;
        end else begin
            r_ref_cnt <= (r_ref_cnt == RC_LAST) ? '0 : (r_ref_cnt + RC_ONE);
            if (r_ref_cnt == '0)  r_ref_done <= 1'b0;
            else if (i_ref_ack)   r_ref_done <= 1'b1;
            if ((r_ref_cnt == RC_LAST) && !r_ref_done && !i_ref_ack)
                r_ref_miss <= 1'b1;
        end
    end

    assign o_n_dtack     = r_n_dtack;
    assign o_n_vpa       = r_n_vpa;
    assign o_n_berr      = r_n_berr;
    assign o_as_active   = w_as_active;
    assign o_as_inactive = w_as_inactive;
    assign o_ref_req     = ~r_ref_done;
    assign o_ref_urgent  = ~r_ref_done & (r_ref_cnt >= RC_URG);
    assign o_ref_miss    = r_ref_miss;

endmodule

// File: tb/tb_fsb_cycle_ctl.sv
module tb_fsb_cycle_ctl;

    localparam int NCH = 4;
    localparam int TMO = 16;
    localparam logic [15:0] WS_VEC = {4'd14, 4'd5, 4'd3, 4'd0};
    localparam logic [3:0]  VPA_M  = 4'b0100;

    int ws_tab [4] = '{0, 3, 5, 14};
    logic [3:0] vpa_tab;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       n_as = 1'b1;
    logic       iacs = 1'b0;
    logic [3:0] cs = '0;
    logic [3:0] rdy = '0;
    logic [3:0] berr = '0;
    logic       ref_ack = 1'b0;
    logic       n_dtack, n_vpa, n_berr, as_act, as_inact;
    logic       ref_req, ref_urg, ref_miss;

    int checks = 0;
    int errors = 0;

    fsb_cycle_ctl #(
        .NCH(NCH), .WSW(4), .WS(WS_VEC), .VPAMASK(VPA_M), .TOW(8),
        .TIMEOUT(TMO), .REF_PERIOD(16), .REF_URGENT(8)
    ) dut (
        .i_fclk(clk), .i_reset(rst), .i_n_as(n_as), .i_iacs(iacs),
        .i_cs(cs), .i_ready(rdy), .i_berr_in(berr),
        .o_n_dtack(n_dtack), .o_n_vpa(n_vpa), .o_n_berr(n_berr),
        .o_as_active(as_act), .o_as_inactive(as_inact),
        .i_ref_ack(ref_ack), .o_ref_req(ref_req),
        .o_ref_urgent(ref_urg), .o_ref_miss(ref_miss)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // 0 none, 1 DTACK, 2 VPA, 3 BERR; 4 means more than one low.
    function automatic int low_kind();
        int n;
        n = int'(!n_dtack) + int'(!n_vpa) + int'(!n_berr);
        if (n == 0) return 0;
        if (n > 1)  return 4;
        if (!n_dtack) return 1;
        if (!n_vpa)   return 2;
        return 3;
    endfunction

    // Reference: which strobe ends the cycle and on which edge after capture.
    function automatic void model(input logic [3:0] c, input logic ia,
                                  input logic [3:0] r, input logic [3:0] b,
                                  output int kind, output int at);
        int ch;
        int rdy_at;
        ch = -1;
        for (int i = 3; i >= 0; i--) if (c[i]) ch = i;
        kind = 3;
        at   = TMO;
        if (ia) begin
            kind = 2;
            at   = 0;
        end else if (ch >= 0) begin
            if (b[ch]) begin
                kind = 3;
                at   = 1;
            end else if (r[ch]) begin
                rdy_at = ws_tab[ch] + 2;
                if (rdy_at <= TMO) begin
                    kind = vpa_tab[ch] ? 2 : 1;
                    at   = rdy_at;
                end
            end
        end
    endfunction

    task automatic do_reset();
        n_as = 1'b1; iacs = 1'b0; cs = '0; rdy = '0; berr = '0; ref_ack = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic run_cycle(input logic [3:0] c, input logic ia,
                             input logic [3:0] r, input logic [3:0] b,
                             input int hold);
        int ek, ea, e, k;
        model(c, ia, r, b, ek, ea);
        cs = c; iacs = ia; rdy = r; berr = b; n_as = 1'b0;
        tick();
        cs = 4'($urandom);
        e = 0;
        k = low_kind();
        while (k == 0 && e < 40) begin
            tick();
            e++;
            k = low_kind();
        end
        checks++;
        if (k != ek) begin
            errors++;
            $display("FAIL term_kind cs=%b iacs=%b rdy=%b berr=%b got=%0d exp=%0d", c, ia, r, b, k, ek);
        end
        checks++;
        if (e != ea) begin
            errors++;
            $display("FAIL term_edge cs=%b iacs=%b rdy=%b berr=%b got=%0d exp=%0d", c, ia, r, b, e, ea);
        end
        for (int h = 0; h < hold; h++) begin
            tick();
            checks++;
            if (low_kind() != ek) begin
                errors++;
                $display("FAIL term_hold cs=%b got=%0d exp=%0d", c, low_kind(), ek);
            end
        end
        n_as = 1'b1;
        tick();
        tick();
        checks++;
        if ({n_dtack, n_vpa, n_berr} !== 3'b111) begin
            errors++;
            $display("FAIL release cs=%b got=%b exp=111", c, {n_dtack, n_vpa, n_berr});
        end
        cs = '0; iacs = 1'b0; rdy = '0; berr = '0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({n_dtack, n_vpa, n_berr} !== 3'b111) begin
            errors++;
            $display("FAIL reset_strobes got=%b exp=111", {n_dtack, n_vpa, n_berr});
        end
        checks++;
        if ({as_act, as_inact} !== 2'b01) begin
            errors++;
            $display("FAIL reset_as got=%b exp=01", {as_act, as_inact});
        end
        checks++;
        if ({ref_req, ref_urg, ref_miss} !== 3'b100) begin
            errors++;
            $display("FAIL reset_ref got=%b exp=100", {ref_req, ref_urg, ref_miss});
        end
    endtask

    task automatic test_directed();
        run_cycle(4'b0010, 1'b0, 4'b1111, 4'b0000, 2);
        run_cycle(4'b0001, 1'b1, 4'b1111, 4'b0000, 1);
        run_cycle(4'b0110, 1'b0, 4'b1111, 4'b0000, 0);
        run_cycle(4'b0100, 1'b0, 4'b1111, 4'b0000, 1);
        run_cycle(4'b0000, 1'b0, 4'b1111, 4'b0000, 0);
        run_cycle(4'b1000, 1'b0, 4'b1000, 4'b0000, 0);
        run_cycle(4'b1000, 1'b0, 4'b0000, 4'b0000, 0);
        run_cycle(4'b0001, 1'b0, 4'b0001, 4'b0001, 1);
        run_cycle(4'b0001, 1'b0, 4'b0001, 4'b0000, 0);
    endtask

    task automatic test_random();
        logic [3:0] c, r, b;
        logic ia;
        for (int n = 0; n < 30; n++) begin
            c  = 4'($urandom);
            r  = 4'($urandom);
            b  = '0;
            for (int i = 0; i < 4; i++) b[i] = ($urandom_range(0, 5) == 0);
            ia = ($urandom_range(0, 7) == 0);
            run_cycle(c, ia, r, b, int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_abort();
        cs = 4'b0001; rdy = '0; n_as = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) tick();
        n_as = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (low_kind() != 0) begin
                errors++;
                $display("FAIL abort_quiet step=%0d got=%0d exp=0", i, low_kind());
            end
        end
        cs = '0;
        tick();
        run_cycle(4'b0100, 1'b0, 4'b0100, 4'b0000, 0);
    endtask

    task automatic test_reset_mid();
        cs = 4'b0100; rdy = '0; n_as = 1'b0;
        tick();
        tick(); tick();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({n_dtack, n_vpa, n_berr} !== 3'b111) begin
            errors++;
            $display("FAIL reset_wait got=%b exp=111", {n_dtack, n_vpa, n_berr});
        end
        n_as = 1'b1; cs = '0;
        tick();
        rst = 1'b0;
        tick();
        cs = 4'b0001; rdy = 4'b0001; n_as = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (n_dtack !== 1'b0) begin
            errors++;
            $display("FAIL term_before_reset got=%b exp=0", n_dtack);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({n_dtack, n_vpa, n_berr} !== 3'b111) begin
            errors++;
            $display("FAIL reset_term got=%b exp=111", {n_dtack, n_vpa, n_berr});
        end
        n_as = 1'b1; cs = '0; rdy = '0;
        tick();
        rst = 1'b0;
        tick();
        run_cycle(4'b0010, 1'b0, 4'b0010, 4'b0000, 0);
    endtask

    // phase 0: never ack; phase 1: ack at count 0 (ignored), count 3, then random.
    task automatic test_refresh(input int phase);
        int served, miss, c, cnow;
        logic a;
        logic er, eu;
        do_reset();
        served = 0;
        miss   = 0;
        for (int n = 1; n <= 48; n++) begin
            c = (n - 1) % 16;
            a = 1'b0;
            if (phase == 1) begin
                if (n == 1 || n == 4) a = 1'b1;
                else if (n > 16)      a = ($urandom_range(0, 9) == 0);
            end
            ref_ack = a;
            tick();
            ref_ack = 1'b0;
            if (c == 15 && served == 0 && !a) miss = 1;
            if (c == 0)  served = 0;
            else if (a)  served = 1;
            cnow = n % 16;
            er = (served == 0);
            eu = (served == 0) && (cnow >= 8);
            checks++;
            if ({ref_req, ref_urg, ref_miss} !== {er, eu, 1'(miss)}) begin
                errors++;
                $display("FAIL refresh ph=%0d n=%0d got=%b exp=%b", phase, n,
                         {ref_req, ref_urg, ref_miss}, {er, eu, 1'(miss)});
            end
        end
    endtask

    initial begin
        vpa_tab = VPA_M;
        test_reset();
        test_directed();
        test_abort();
        test_reset_mid();
        test_random();
        test_refresh(0);
        test_refresh(1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule
